// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-requester ALU arbiter: controller states,
// default widths and the bit positions of the packed response flags.
package alu_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 5;

    localparam int NUM_FLAGS     = 4;
    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_PARITY   = 2;
    localparam int FLAG_NEG      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester that did not win last
// time is chosen; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_any
);

    always_comb begin
        grant_any = |valid;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = valid[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and returns the
// registered result and flags through a valid/ready response port.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operands on acceptance
// EXEC  | operand registers drive the ALU; result and flags captured at edge
// RESP  | response held on rsp_* until rsp_ready
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_op_a,
    input  logic [WIDTH-1:0] req0_op_b,
    input  logic [WIDTH-1:0] req1_op_a,
    input  logic [WIDTH-1:0] req1_op_b,
    input  logic [OPW-1:0]   req0_op_code,
    input  logic [OPW-1:0]   req1_op_code,
    output logic [WIDTH-1:0] alu_op_a,
    output logic [WIDTH-1:0] alu_op_b,
    output logic [OPW-1:0]   alu_op_code,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag_carry,
    input  logic             alu_flag_overflow,
    input  logic             alu_flag_parity,
    input  logic             alu_flag_neg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       op_a_q, op_b_q, result_q;
    logic [OPW-1:0]         op_code_q;
    logic                   id_q;
    logic                   last_grant_q;
    logic [NUM_FLAGS-1:0]   flags_q;
    logic                   grant;
    logic                   grant_any;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_any  (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is gated by rst so no requester believes it was accepted by a
    // cycle that the reset is about to discard.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (!rst && grant_any) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                end
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_code_q    <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            if (state_q == ST_IDLE && grant_any) begin
                op_a_q       <= grant ? req1_op_a    : req0_op_a;
                op_b_q       <= grant ? req1_op_b    : req0_op_b;
                op_code_q    <= grant ? req1_op_code : req0_op_code;
                id_q         <= grant;
                last_grant_q <= grant;
            end
            if (state_q == ST_EXEC) begin
                result_q                <= alu_out;
                flags_q[FLAG_CARRY]     <= alu_flag_carry;
                flags_q[FLAG_OVERFLOW]  <= alu_flag_overflow;
                flags_q[FLAG_PARITY]    <= alu_flag_parity;
                flags_q[FLAG_NEG]       <= alu_flag_neg;
            end
        end
    end

    assign alu_op_a    = op_a_q;
    assign alu_op_b    = op_b_q;
    assign alu_op_code = op_code_q;
    assign rsp_id      = id_q;
    assign rsp_result  = result_q;
    assign rsp_flags   = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run, checked
// against a transaction-level model of grant order, latency and ALU results.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [4:0]  req0_op_code, req1_op_code;
    logic [31:0] alu_op_a, alu_op_b, alu_out;
    logic [4:0]  alu_op_code;
    logic        alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    bit          alu_force = 1'b0;
    logic [35:0] alu_res;

    int n_pass = 0;
    int n_chk  = 0;

    // Transaction-level model state
    bit          v[2];
    logic [31:0] pa[2], pb[2];
    logic [4:0]  pc[2];
    bit          m_idle, m_last, m_id;
    logic [35:0] m_exp;
    int          acc_t, cyc;
    int          gq[$];
    int          gt[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clk (clk), .rst (rst),
        .req0_valid (req0_valid), .req1_valid (req1_valid),
        .req0_ready (req0_ready), .req1_ready (req1_ready),
        .req0_op_a (req0_op_a), .req0_op_b (req0_op_b),
        .req1_op_a (req1_op_a), .req1_op_b (req1_op_b),
        .req0_op_code (req0_op_code), .req1_op_code (req1_op_code),
        .alu_op_a (alu_op_a), .alu_op_b (alu_op_b), .alu_op_code (alu_op_code),
        .alu_out (alu_out),
        .alu_flag_carry (alu_flag_carry), .alu_flag_overflow (alu_flag_overflow),
        .alu_flag_parity (alu_flag_parity), .alu_flag_neg (alu_flag_neg),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
        .rsp_result (rsp_result), .rsp_flags (rsp_flags), .busy (busy)
    );

    // Returns {neg, parity, overflow, carry, out}
    function automatic logic [35:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                           logic [4:0] c, bit f);
        logic [32:0] s;
        logic [31:0] o;
        logic        ovf;
        if (f) return {4'b1001, 32'h8000_0000};
        if (c[4]) s = {1'b0, a} - {1'b0, b};
        else      s = {1'b0, a} + {1'b0, b};
        o   = s[31:0];
        ovf = c[4] ? ((a[31] != b[31]) && (o[31] != a[31]))
                   : ((a[31] == b[31]) && (o[31] != a[31]));
        return {o[31], ^o, ovf, s[32], o};
    endfunction

    always_comb alu_res = alu_fn(alu_op_a, alu_op_b, alu_op_code, alu_force);
    assign alu_out           = alu_res[31:0];
    assign alu_flag_carry    = alu_res[32];
    assign alu_flag_overflow = alu_res[33];
    assign alu_flag_parity   = alu_res[34];
    assign alu_flag_neg      = alu_res[35];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        req0_valid = v[0]; req0_op_a = pa[0]; req0_op_b = pb[0]; req0_op_code = pc[0];
        req1_valid = v[1]; req1_op_a = pa[1]; req1_op_b = pb[1]; req1_op_code = pc[1];
    endtask

    task automatic model_reset();
        v[0] = 1'b0; v[1] = 1'b0;
        m_idle = 1'b1;
        m_last = 1'b1;
    endtask

    // One op occupies the block from its acceptance cycle until the response
    // handshake; the response appears two cycles after acceptance.
    task automatic run(input int n, input int pv, input int pr);
        bit g;
        int lat;
        for (int k = 0; k < n; k++) begin
            step();
            cyc++;
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 99) < pv) begin
                    v[r]  = 1'b1;
                    pa[r] = $urandom;
                    pb[r] = $urandom;
                    pc[r] = 5'($urandom_range(0, 31));
                end
            end
            drive_reqs();
            rsp_ready = ($urandom_range(0, 99) < pr);
            #1;
            if (m_idle) begin
                g = (v[0] && v[1]) ? !m_last : v[1];
                chk("ready0_idle", 64'(req0_ready), 64'(v[0] && (v[0] || v[1]) && g == 1'b0));
                chk("ready1_idle", 64'(req1_ready), 64'(v[1] && g == 1'b1));
                chk("busy_idle", 64'(busy), 64'(0));
                chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
                if (v[0] || v[1]) begin
                    m_idle = 1'b0;
                    m_last = g;
                    m_id   = g;
                    m_exp  = alu_fn(pa[g], pb[g], pc[g], alu_force);
                    acc_t  = cyc;
                    v[g]   = 1'b0;
                    gq.push_back(int'(g));
                    gt.push_back(cyc);
                end
            end else begin
                lat = cyc - acc_t;
                chk("ready0_busy", 64'(req0_ready), 64'(0));
                chk("ready1_busy", 64'(req1_ready), 64'(0));
                chk("busy_busy", 64'(busy), 64'(1));
                chk("rsp_valid_lat", 64'(rsp_valid), 64'(lat >= 2));
                if (lat >= 2) begin
                    chk("rsp_id", 64'(rsp_id), 64'(m_id));
                    chk("rsp_result", 64'(rsp_result), 64'(m_exp[31:0]));
                    chk("rsp_flags", 64'(rsp_flags), 64'(m_exp[35:32]));
                    if (rsp_ready) m_idle = 1'b1;
                end
            end
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        pa[0] = '0; pb[0] = '0; pc[0] = '0; pa[1] = '0; pb[1] = '0; pc[1] = '0;
        drive_reqs();
        rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_result", 64'(rsp_result), 64'(0));
        chk("rst_flags", 64'(rsp_flags), 64'(0));
        chk("rst_id", 64'(rsp_id), 64'(0));
        chk("rst_alu_a", 64'(alu_op_a), 64'(0));

        // Single request from req0: 5 - 3
        req0_valid = 1'b1; req0_op_a = 32'd5; req0_op_b = 32'd3; req0_op_code = 5'b10000;
        #1;
        chk("rst_ready0", 64'(req0_ready), 64'(0));
        step();
        rst = 1'b0;
        #1;
        chk("single_ready0_T", 64'(req0_ready), 64'(1));
        chk("single_ready1_T", 64'(req1_ready), 64'(0));
        step();
        req0_valid = 1'b0;
        #1;
        chk("single_busy_T1", 64'(busy), 64'(1));
        chk("single_valid_T1", 64'(rsp_valid), 64'(0));
        chk("single_alu_a", 64'(alu_op_a), 64'(5));
        chk("single_alu_code", 64'(alu_op_code), 64'(5'b10000));
        step();
        rsp_ready = 1'b1;
        #1;
        chk("single_valid_T2", 64'(rsp_valid), 64'(1));
        chk("single_id", 64'(rsp_id), 64'(0));
        chk("single_result", 64'(rsp_result), 64'(2));
        chk("single_flags", 64'(rsp_flags), 64'(4'b0100));
        step();
        rsp_ready = 1'b0;
        #1;
        chk("single_done_valid", 64'(rsp_valid), 64'(0));
        chk("single_done_busy", 64'(busy), 64'(0));

        // Reset while an op from req1 is in EXEC
        req1_valid = 1'b1; req1_op_a = 32'hFFFF_FFFF; req1_op_b = 32'd1; req1_op_code = 5'd0;
        #1;
        chk("abort_ready1", 64'(req1_ready), 64'(1));
        step();
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_in_exec", 64'(busy), 64'(1));
        step();
        chk("abort_idle", 64'(busy), 64'(0));
        chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
        chk("abort_result", 64'(rsp_result), 64'(0));
        rsp_ready = 1'b1;
        rst = 1'b0;
        step();
        chk("abort_still_no_rsp", 64'(rsp_valid), 64'(0));
        step();
        chk("abort_later_no_rsp", 64'(rsp_valid), 64'(0));

        // Contention from a fresh reset: 0,1,0,1 at 3-cycle spacing
        model_reset();
        gq.delete();
        gt.delete();
        run(12, 100, 100);
        chk("cont_count", 64'(gq.size() >= 4), 64'(1));
        if (gq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("cont_grant", 64'(gq[i]), 64'(i % 2));
                if (i > 0) chk("cont_spacing", 64'(gt[i] - gt[i-1]), 64'(3));
            end
        end

        // Backpressure: response held while rsp_ready stays low
        run(9, 100, 0);
        run(8, 100, 100);

        // Flag pass-through
        run(8, 0, 100);
        alu_force = 1'b1;
        run(4, 100, 0);
        chk("flags_1001", 64'(rsp_flags), 64'(4'b1001));
        chk("flags_result", 64'(rsp_result), 64'(32'h8000_0000));
        run(10, 0, 100);
        alu_force = 1'b0;

        run(400, 40, 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
